// File: rtl/push_pull_fifo_pkg.sv
// Shared helpers for the push-pull fifo pair. Sender and receiver both size
// their fifo/credit count from fifo_depth() so the two can never disagree.
package push_pull_fifo_pkg;

  // Ceiling log2; log2(1) = 0, log2(5) = 3.
  function automatic int log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Registered sender inputs add two words of round-trip latency to cover.
  function automatic int fifo_depth(input int extra_fifo_depth, input int no_input_regs);
    return extra_fifo_depth + ((no_input_regs != 0) ? 2 : 4);
  endfunction

endpackage

// File: rtl/push_pull_fifo_ram.sv
// Single-write, asynchronous-read register array backing the receive fifo.
module push_pull_fifo_ram #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // NOTE: the array has no reset; occupancy is tracked by the count in the
  // parent, so stale contents are never presented as valid.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/push_pull_fifo_in.sv
// Receive end of the push-pull fifo link: buffers sender words, shows the head
// to the parent, and returns one credit pulse upstream per popped word.
module push_pull_fifo_in
  import push_pull_fifo_pkg::*;
#(
  parameter int dataWidth         = 128,
  parameter int extraFifoDepth    = 0,
  parameter int senderNoInputRegs = 0,
  parameter int noOutputRegs      = 0,
  localparam int FIFO_DEPTH = fifo_depth(extraFifoDepth, senderNoInputRegs),
  localparam int LVL_W      = log2(FIFO_DEPTH + 1)
) (
  input  logic                 mclk,
  input  logic                 reset,
  input  logic                 readRun_r,
  input  logic                 clearErrors_r,
  input  logic                 xferFromPrev,
  input  logic [dataWidth-1:0] dataFromPrev,
  output logic                 reqToPrev,
  input  logic                 popFromParent,
  output logic                 dataValidToParent,
  output logic [dataWidth-1:0] dataToParent,
  output logic [LVL_W-1:0]     fifoLevel,
  output logic                 overflowError,
  output logic                 underflowError
);

  localparam int                PTR_W    = (log2(FIFO_DEPTH) < 1) ? 1 : log2(FIFO_DEPTH);
  localparam logic [LVL_W-1:0]  FULL_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [LVL_W-1:0] r_count;
  logic             r_overflow, r_underflow;

  logic w_full, w_empty, w_pop, w_push, w_overflow_evt, w_underflow_evt;
  logic [PTR_W-1:0] w_wr_ptr_nxt, w_rd_ptr_nxt;

  assign w_full  = (r_count == FULL_LVL);
  assign w_empty = (r_count == '0);

  // A push into a full fifo is legal when the head leaves at the same edge.
  assign w_pop           = popFromParent & ~w_empty & readRun_r;
  assign w_push          = xferFromPrev & readRun_r & (~w_full | w_pop);
  assign w_overflow_evt  = xferFromPrev & readRun_r & w_full & ~w_pop;
  assign w_underflow_evt = popFromParent & readRun_r & w_empty;

  assign w_wr_ptr_nxt = (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
  assign w_rd_ptr_nxt = (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge mclk) begin
    if (reset || !readRun_r) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= w_wr_ptr_nxt;
      if (w_pop)  r_rd_ptr <= w_rd_ptr_nxt;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  // A fresh error event wins over a simultaneous clear.
  always_ff @(posedge mclk) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= (r_overflow  & ~clearErrors_r) | w_overflow_evt;
      r_underflow <= (r_underflow & ~clearErrors_r) | w_underflow_evt;
    end
  end

  push_pull_fifo_ram #(
    .DATA_W (dataWidth),
    .DEPTH  (FIFO_DEPTH),
    .ADDR_W (PTR_W)
  ) u_ram (
    .clk       (mclk),
    .i_wr_en   (w_push),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (dataFromPrev),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (dataToParent)
  );

  generate
    if (noOutputRegs != 0) begin : g_comb_req
      assign reqToPrev = w_pop;
    end else begin : g_reg_req
      logic r_req;
      always_ff @(posedge mclk) begin
        if (reset || !readRun_r) r_req <= 1'b0;
        else                     r_req <= w_pop;
      end
      // Dropping readRun_r also kills a pulse already sitting in the register.
      assign reqToPrev = r_req & readRun_r;
    end
  endgenerate

  assign dataValidToParent = ~w_empty;
  assign fifoLevel         = r_count;
  assign overflowError     = r_overflow;
  assign underflowError    = r_underflow;

`ifdef SIM_ASSERT
  always_ff @(posedge mclk) begin
    if (!reset && readRun_r)
      assert (!$isunknown({xferFromPrev, popFromParent}))
        else $error("push_pull_fifo_in: X on xferFromPrev/popFromParent");
  end
  assert property (@(posedge mclk) !$rose(r_overflow))
    else $error("push_pull_fifo_in: overflow");
  assert property (@(posedge mclk) !$rose(r_underflow))
    else $error("push_pull_fifo_in: underflow");
`endif

endmodule

// File: tb/tb_push_pull_fifo_in.sv
// Scoreboard bench for push_pull_fifo_in: a queue-based reference model sets
// expectations per cycle; a negedge monitor compares whatever the DUT shows.
module tb_push_pull_fifo_in;

  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic          mclk = 1'b0;
  logic          reset, readRun_r, clearErrors_r, xferFromPrev, popFromParent;
  logic [DW-1:0] dataFromPrev;
  logic          reqToPrev, dataValidToParent, overflowError, underflowError;
  logic [DW-1:0] dataToParent;
  logic [2:0]    fifoLevel;

  always #5 mclk = ~mclk;

  push_pull_fifo_in #(
    .dataWidth         (DW),
    .extraFifoDepth    (0),
    .senderNoInputRegs (0),
    .noOutputRegs      (0)
  ) dut (
    .mclk              (mclk),
    .reset             (reset),
    .readRun_r         (readRun_r),
    .clearErrors_r     (clearErrors_r),
    .xferFromPrev      (xferFromPrev),
    .dataFromPrev      (dataFromPrev),
    .reqToPrev         (reqToPrev),
    .popFromParent     (popFromParent),
    .dataValidToParent (dataValidToParent),
    .dataToParent      (dataToParent),
    .fifoLevel         (fifoLevel),
    .overflowError     (overflowError),
    .underflowError    (underflowError)
  );

  typedef struct {
    logic          valid;
    int            level;
    logic          req;
    logic          ovf;
    logic          unf;
    logic [DW-1:0] head;
  } exp_t;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: fifo contents as a queue plus sticky flags.
  logic [DW-1:0] m_q[$];
  logic          m_last_pop, m_ovf, m_unf;

  exp_t          exp_q[$];
  logic [DW-1:0] sb_data[$];
  exp_t          mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic xfer, input logic [DW-1:0] d, input logic pop,
                       input logic run, input logic clr, input logic rst);
    exp_t e;
    logic acc_pop, acc_push, ovf_evt, unf_evt;
    @(posedge mclk);
    #1;
    xferFromPrev  = xfer;
    dataFromPrev  = d;
    popFromParent = pop;
    readRun_r     = run;
    clearErrors_r = clr;
    reset         = rst;

    e.valid = (m_q.size() != 0);
    e.level = m_q.size();
    e.req   = m_last_pop & run;
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    e.head  = e.valid ? m_q[0] : '0;
    exp_q.push_back(e);

    if (rst) begin
      m_q.delete();
      m_last_pop = 1'b0;
      m_ovf      = 1'b0;
      m_unf      = 1'b0;
    end else begin
      acc_pop  = run && pop && (m_q.size() > 0);
      acc_push = run && xfer && ((m_q.size() < DEPTH) || acc_pop);
      ovf_evt  = run && xfer && (m_q.size() == DEPTH) && !acc_pop;
      unf_evt  = run && pop && (m_q.size() == 0);
      if (acc_pop)  sb_data.push_back(m_q.pop_front());
      if (acc_push) m_q.push_back(d);
      if (!run)     m_q.delete();
      m_last_pop = acc_pop;
      m_ovf = (m_ovf & ~clr) | ovf_evt;
      m_unf = (m_unf & ~clr) | unf_evt;
    end
  endtask

  always @(negedge mclk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("valid",     dataValidToParent, mon_e.valid);
      check("level",     fifoLevel,         mon_e.level);
      check("req",       reqToPrev,         mon_e.req);
      check("overflow",  overflowError,     mon_e.ovf);
      check("underflow", underflowError,    mon_e.unf);
      if (mon_e.valid) check("head", dataToParent, mon_e.head);
    end
    if (!reset && readRun_r && popFromParent && dataValidToParent) begin
      if (sb_data.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL pop_data: got %0h expected no pop (scoreboard empty) at %0t",
                 dataToParent, $time);
      end else begin
        check("pop_data", dataToParent, sb_data.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1; readRun_r = 1'b0; clearErrors_r = 1'b0;
    xferFromPrev = 1'b0; popFromParent = 1'b0; dataFromPrev = '0;
    m_last_pop = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    repeat (2) @(posedge mclk);

    // Reset state, then underflow and clear.
    cycle(0, '0, 0, 1, 0, 0);
    cycle(0, '0, 1, 1, 0, 0);
    cycle(0, '0, 0, 1, 0, 0);
    cycle(0, '0, 0, 1, 1, 0);

    // Fill to full, overflow, clear racing a new overflow, then clear alone.
    for (int i = 0; i < DEPTH; i++) cycle(1, DW'(16'hA0 + i), 0, 1, 0, 0);
    cycle(1, 16'hB5, 0, 1, 0, 0);
    cycle(1, 16'hB6, 0, 1, 1, 0);
    cycle(0, '0, 0, 1, 1, 0);
    cycle(0, '0, 0, 1, 0, 0);

    // Simultaneous push/pop at full, then drain in order.
    cycle(1, 16'hB4, 1, 1, 0, 0);
    for (int i = 0; i < DEPTH; i++) cycle(0, '0, 1, 1, 0, 0);
    cycle(0, '0, 0, 1, 0, 0);
    cycle(0, '0, 0, 1, 0, 0);

    // readRun_r drop with a pop in flight.
    for (int i = 0; i < 3; i++) cycle(1, DW'(16'hC0 + i), 0, 1, 0, 0);
    cycle(0, '0, 1, 1, 0, 0);
    cycle(0, '0, 0, 0, 0, 0);
    cycle(0, '0, 0, 1, 0, 0);

    // Same through the reset pin.
    for (int i = 0; i < 3; i++) cycle(1, DW'(16'hD0 + i), 0, 1, 0, 0);
    cycle(0, '0, 1, 1, 0, 0);
    cycle(0, '0, 0, 1, 0, 1);
    cycle(0, '0, 0, 1, 0, 0);

    // Randomized traffic with occasional clears, run drops and resets.
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 9) < 6, DW'($urandom),
            $urandom_range(0, 9) < 5,
            $urandom_range(0, 99) >= 3,
            $urandom_range(0, 99) < 5,
            $urandom_range(0, 199) < 2);
    end
    cycle(0, '0, 0, 1, 0, 0);

    @(negedge mclk);
    #1;
    check("sb_drain", sb_data.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
